// File: rtl/tb_tcdm_load_master_if.sv
// Single-port 32-bit TCDM bus between a master (request side) and a slave
// (memory side).
//
// Handshake semantics: a request is accepted on the rising edge where both
// req and gnt are high; while req is high and gnt low, the master holds
// add/wen/be/data stable. The slave answers an accepted read one cycle later
// with r_valid high for exactly one cycle together with r_data. There is no
// back-pressure on the response channel.
interface hwpe_stream_intf_tcdm;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (
    output req, add, wen, be, data,
    input  gnt, r_data, r_valid
  );

  modport slave (
    input  req, add, wen, be, data,
    output gnt, r_data, r_valid
  );
endinterface

// File: rtl/tb_tcdm_load_master.sv
// Strided TCDM read master. Issues len word reads starting at base, spaced by
// stride bytes, and turns the read responses into a valid/ready stream.
// Requests are only issued while the response buffer has room for every read
// already in flight, so a stalled stream consumer can never overflow it.
module tb_tcdm_load_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [31:0]          stride_i,
  input  logic [CNT_W-1:0]     len_i,
  hwpe_stream_intf_tcdm.master tcdm,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [31:0]          data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [1:0]           state_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q;
  logic [31:0]      stride_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] popped_q;
  logic [CNT_W-1:0] popped_next;
  logic             inflight_q;
  logic             err_q;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;

  logic credit_ok;
  logic hs;
  logic push;
  logic pop;

  // Credit uses registered occupancy only: no path from ready_i to req.
  assign credit_ok   = ((CW+1)'(cnt_q) + (CW+1)'(inflight_q)) < (CW+1)'(FIFO_DEPTH);
  assign hs          = tcdm.req & tcdm.gnt;
  assign push        = tcdm.r_valid & inflight_q;
  assign pop         = valid_o & ready_i;
  assign popped_next = popped_q + CNT_W'(pop);

  // Bus and stream outputs decoded from registered state.
  always_comb begin
    tcdm.req  = (state_q == ISSUE) && credit_ok;
    tcdm.add  = addr_q;
    tcdm.wen  = 1'b1;
    tcdm.be   = (state_q == ISSUE) ? 4'hF : 4'h0;
    tcdm.data = '0;
    valid_o   = (cnt_q != '0);
    data_o    = (cnt_q != '0) ? mem[rptr_q] : '0;
    busy_o    = (state_q == ISSUE) || (state_q == DRAIN);
    done_o    = (state_q == DONE);
    err_o     = err_q;
    state_o   = state_q;
  end

  // Next-state logic; DRAIN looks at the pop of this cycle so done_o follows
  // the final pop directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (len_i == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (hs && (idx_q == len_q - CNT_W'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (popped_next == len_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Transfer parameters, address walk, counters and the sticky error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= hs;
      if (tcdm.r_valid && !inflight_q) begin
        err_q <= 1'b1;
      end
      if ((state_q == IDLE) && start_i) begin
        addr_q   <= base_addr_i;
        stride_q <= stride_i;
        len_q    <= len_i;
        idx_q    <= '0;
        popped_q <= '0;
      end else begin
        // Incremental add keeps addr_q == base + idx*stride modulo 2^32.
        if (hs) begin
          idx_q  <= idx_q + CNT_W'(1);
          addr_q <= addr_q + stride_q;
        end
        if (pop) begin
          popped_q <= popped_next;
        end
      end
    end
  end

  // Response buffer pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        wptr_q <= (wptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= (rptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Response buffer storage; contents are don't-care while empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr_q] <= tcdm.r_data;
    end
  end

endmodule

// File: tb/tb_tb_tcdm_load_master.sv
// Bench for the strided TCDM read master: a one-cycle-latency memory model
// with random grant stalls, and a scoreboard of expected stream words and
// expected request addresses.
module tb_tb_tcdm_load_master;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic [31:0]      base_addr;
  logic [31:0]      stride;
  logic [CNT_W-1:0] len;
  logic             valid;
  logic             ready;
  logic [31:0]      data;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       state;

  hwpe_stream_intf_tcdm tcdm ();

  tb_tcdm_load_master #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .base_addr_i (base_addr),
    .stride_i    (stride),
    .len_i       (len),
    .tcdm        (tcdm),
    .valid_o     (valid),
    .ready_i     (ready),
    .data_o      (data),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .state_o     (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int grant_cnt = 0;
  int pop_cnt   = 0;
  int stall_pct = 0;
  logic spur = 1'b0;
  logic rv_q;
  logic prev_wait = 1'b0;
  logic [31:0] prev_add = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_1000 + (a >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // memory model: random grant, response one cycle after the grant
  always @(posedge clk) begin
    #1;
    tcdm.gnt = ($urandom_range(0, 99) >= stall_pct);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rv_q        <= 1'b0;
      tcdm.r_data <= '0;
    end else begin
      rv_q        <= tcdm.req & tcdm.gnt;
      tcdm.r_data <= mem_word(tcdm.add);
    end
  end

  assign tcdm.r_valid = rv_q | spur;

  // monitor: stream pops, request addresses, address stability under stall
  always @(negedge clk) begin
    if (rst) begin
      prev_wait = 1'b0;
    end else begin
      if (valid && ready) begin
        pop_cnt++;
        if (exp_q.size() > 0) chk("stream_data", data, exp_q.pop_front());
        else chk("unexpected_pop", 32'd1, 32'd0);
      end
      if (prev_wait) chk("add_stable", tcdm.add, prev_add);
      if (tcdm.req && tcdm.gnt) begin
        grant_cnt++;
        if (exp_addr_q.size() > 0) chk("req_add", tcdm.add, exp_addr_q.pop_front());
        else chk("extra_request", 32'd1, 32'd0);
      end
      prev_wait = tcdm.req & ~tcdm.gnt;
      prev_add  = tcdm.add;
    end
  end

  // driver: pulse start and record expectations; returns on the first
  // negedge after the sampling edge
  task automatic start_xfer(input logic [31:0] b, input logic [31:0] s, input int n);
    @(negedge clk);
    base_addr = b;
    stride    = s;
    len       = CNT_W'(n);
    start     = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(b + 32'(i) * s);
      exp_q.push_back(mem_word(b + 32'(i) * s));
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 1;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  int n;
  int seen_req;

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; stride = '0; len = '0; ready = 1'b1;
    repeat (3) @(negedge clk);
    // reset values
    chk("rst_req",   {31'd0, tcdm.req}, 32'd0);
    chk("rst_add",   tcdm.add, 32'd0);
    chk("rst_wen",   {31'd0, tcdm.wen}, 32'd1);
    chk("rst_be",    {28'd0, tcdm.be}, 32'd0);
    chk("rst_data",  tcdm.data, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_out",   data, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic read
    stall_pct = 0; ready = 1'b1; pop_cnt = 0;
    start_xfer(32'h0, 32'd4, 8);
    chk("basic_req_cycle1", {31'd0, tcdm.req}, 32'd1);
    chk("basic_add_first", tcdm.add, 32'h0);
    chk("basic_be", {28'd0, tcdm.be}, 32'hF);
    wait_done(40, n);
    chk("basic_done_cycle", 32'(n), 32'd11);
    chk("basic_busy_at_done", {31'd0, busy}, 32'd0);
    chk("basic_pops", 32'(pop_cnt), 32'd8);
    chk("basic_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    chk("basic_done_pulse", {31'd0, done}, 32'd0);
    chk("basic_exp_empty", 32'(exp_q.size()), 32'd0);

    // grant stalls
    stall_pct = 50; pop_cnt = 0;
    start_xfer(32'h100, 32'd8, 64);
    wait_done(2000, n);
    chk("stall_pops", 32'(pop_cnt), 32'd64);
    chk("stall_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("stall_addr_empty", 32'(exp_addr_q.size()), 32'd0);
    stall_pct = 0;
    repeat (2) @(negedge clk);

    // backpressure
    ready = 1'b0; grant_cnt = 0; pop_cnt = 0;
    start_xfer(32'h40, 32'd4, 16);
    repeat (20) @(negedge clk);
    chk("bp_grants", 32'(grant_cnt), 32'd4);
    chk("bp_req_low", {31'd0, tcdm.req}, 32'd0);
    chk("bp_valid", {31'd0, valid}, 32'd1);
    ready = 1'b1;
    wait_done(200, n);
    chk("bp_pops", 32'(pop_cnt), 32'd16);
    chk("bp_exp_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    // zero length
    seen_req = 0;
    start_xfer(32'h0, 32'd4, 0);
    n = 1;
    if (tcdm.req) seen_req = 1;
    while (!done && n < 4) begin
      @(negedge clk);
      n++;
      if (tcdm.req) seen_req = 1;
    end
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_no_req", 32'(seen_req), 32'd0);
    @(negedge clk);
    chk("zero_idle", {31'd0, busy | done}, 32'd0);

    // address wrap-around
    start_xfer(32'hFFFF_FFF8, 32'd4, 4);
    wait_done(40, n);
    chk("wrap_addr_empty", 32'(exp_addr_q.size()), 32'd0);
    chk("wrap_exp_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    // reset mid-transfer
    grant_cnt = 0;
    start_xfer(32'h800, 32'd4, 10);
    n = 0;
    while (grant_cnt < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_grants", {31'd0, grant_cnt >= 3}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, tcdm.req}, 32'd0);
    chk("mid_rst_add", tcdm.add, 32'd0);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_out", data, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_be", {28'd0, tcdm.be}, 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pop_cnt = 0;
    start_xfer(32'h900, 32'd4, 5);
    wait_done(60, n);
    chk("mid_restart_pops", 32'(pop_cnt), 32'd5);
    chk("mid_restart_err", {31'd0, err}, 32'd0);
    chk("mid_restart_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    // spurious response while idle
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("spur_err", {31'd0, err}, 32'd1);
    chk("spur_valid", {31'd0, valid}, 32'd0);
    chk("spur_out", data, 32'd0);
    repeat (3) @(negedge clk);
    chk("spur_err_sticky", {31'd0, err}, 32'd1);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
